// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: a four-state controller (IDLE/LOAD/RUN/PAUSE) that
// loads a per-mode seed into an 8-bit LED register and then steps it once
// every PRESCALE clock cycles while running. Bit 7 is the leftmost LED.
module led_pattern_sequencer #(
  parameter int unsigned PRESCALE = 4  // clk cycles per pattern step, 1..255
) (
  input  logic       clk,
  input  logic       reset,     // asynchronous, active-low
  input  logic       en,
  input  logic       mode_req,
  input  logic [2:0] mode,
  output logic       mode_ack,
  output logic       tick,
  output logic       active,
  output logic [7:0] q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  // Bounce direction encoding: left means shifting toward bit 7.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Last prescaler count before a wrap; with PRESCALE=1 every RUN cycle wraps.
  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  state_t     state_q, state_d;
  logic [7:0] pat_q, pat_d;
  logic [7:0] presc_q, presc_d;
  logic [2:0] mode_q, mode_d;
  logic       dir_q, dir_d;
  logic       mode_ack_q, mode_ack_d;
  logic       tick_q, tick_d;

  // Values produced by the per-mode seed and step rules.
  logic [7:0] seed_pat;
  logic       seed_valid;
  logic [7:0] step_pat;
  logic       step_dir;

  // Seed lookup for the latched mode; reserved modes report seed_valid=0.
  always_comb begin
    seed_pat   = 8'h00;
    seed_valid = 1'b1;
    case (mode_q)
      3'd1:    seed_pat = 8'h01;
      3'd2:    seed_pat = 8'h80;
      3'd3:    seed_pat = 8'h00;
      3'd4:    seed_pat = 8'h00;
      3'd5:    seed_pat = 8'h01;
      default: begin
        seed_pat   = 8'h00;
        seed_valid = 1'b0;
      end
    endcase
  end

  // One-step advance of the pattern for the latched mode. The bounce mode
  // turns around on the step that leaves an end, so each end is shown once.
  always_comb begin
    step_pat = pat_q;
    step_dir = dir_q;
    case (mode_q)
      3'd1: step_pat = {pat_q[6:0], pat_q[7]};
      3'd2: step_pat = {pat_q[0], pat_q[7:1]};
      3'd3: step_pat = {~pat_q[0], pat_q[7:1]};
      3'd4: step_pat = {pat_q[6:0], ~pat_q[7]};
      3'd5: begin
        if (dir_q == DIR_LEFT) begin
          if (pat_q == 8'h80) begin
            step_pat = 8'h40;
            step_dir = DIR_RIGHT;
          end else begin
            step_pat = {pat_q[6:0], 1'b0};
          end
        end else begin
          if (pat_q == 8'h01) begin
            step_pat = 8'h02;
            step_dir = DIR_LEFT;
          end else begin
            step_pat = {1'b0, pat_q[7:1]};
          end
        end
      end
      default: step_pat = pat_q;
    endcase
  end

  // Next-state logic: a mode request outranks pausing and stepping, so a
  // request that coincides with a prescaler wrap suppresses that step.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    presc_d    = presc_q;
    mode_d     = mode_q;
    dir_d      = dir_q;
    mode_ack_d = 1'b0;
    tick_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        pat_d = 8'h00;
        if (mode_req) begin
          mode_d     = mode;
          state_d    = S_LOAD;
          mode_ack_d = 1'b1;
        end
      end

      // Single-cycle load; requests arriving here are neither taken nor acked.
      S_LOAD: begin
        presc_d = 8'd0;
        dir_d   = DIR_LEFT;
        if (seed_valid) begin
          pat_d   = seed_pat;
          state_d = en ? S_RUN : S_PAUSE;
        end else begin
          pat_d   = 8'h00;
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (mode_req) begin
          mode_d     = mode;
          state_d    = S_LOAD;
          mode_ack_d = 1'b1;
        end else if (!en) begin
          state_d = S_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = 8'd0;
          tick_d  = 1'b1;
          pat_d   = step_pat;
          dir_d   = step_dir;
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end

      // Pattern and prescaler hold; counting resumes from the held value.
      S_PAUSE: begin
        if (mode_req) begin
          mode_d     = mode;
          state_d    = S_LOAD;
          mode_ack_d = 1'b1;
        end else if (en) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
        pat_d   = 8'h00;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pat_q      <= 8'h00;
      presc_q    <= 8'd0;
      mode_q     <= 3'd0;
      dir_q      <= DIR_LEFT;
      mode_ack_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      presc_q    <= presc_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      mode_ack_q <= mode_ack_d;
      tick_q     <= tick_d;
    end
  end

  assign q        = pat_q;
  assign mode_ack = mode_ack_q;
  assign tick     = tick_q;
  assign active   = (state_q == S_RUN);

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 Parameter: PRESCALE, 4, number of clk cycles per pattern step (legal range 1..255).
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: en  input  1  run enable; 0 pauses stepping.
REQ-005 Port: mode_req  input  1  level request to load the mode on `mode`.
REQ-006 Port: mode  input  3  requested pattern; sampled only when a request is accepted.
REQ-007 Port: mode_ack  output  1  registered one-cycle acceptance pulse.
REQ-008 Port: tick  output  1  registered one-cycle step strobe.
REQ-009 Port: active  output  1  high while the FSM is in RUN.
REQ-010 Port: q  output  8  LED pattern register (bit 7 is the leftmost LED).

Function
REQ-011 The FSM SHALL have four states: IDLE, LOAD, RUN and PAUSE.
REQ-012 In IDLE, RUN or PAUSE, mode_req=1 SHALL be accepted on that edge: latch mode, enter LOAD, and drive mode_ack=1 for the following cycle only.
REQ-013 In LOAD, mode_req SHALL be ignored and not acknowledged; the requester must deassert mode_req in the cycle it sees mode_ack.
REQ-014 LOAD lasts exactly one cycle and SHALL do all of the following:
  - load q with the mode seed;
  - clear the prescaler;
  - set the bounce direction to left;
  - go to RUN if en=1, else PAUSE.
REQ-015 Modes 0, 6 and 7 SHALL, in LOAD, set q=8'h00 and go to IDLE; mode_ack is still issued.
REQ-016 In RUN, the prescaler SHALL count 0..PRESCALE-1 and wrap to 0.
  - tick=1 for the cycle after the count reaches PRESCALE-1.
  - q advances on the same edge that sets tick.
  - PRESCALE=1 gives a step on every RUN cycle.
REQ-017 Per-mode seed and step rule:
  - mode 1, ring left: seed 8'h01; q <= {q[6:0],q[7]}.
  - mode 2, ring right: seed 8'h80; q <= {q[0],q[7:1]}.
  - mode 3, interleaved on/off right: seed 8'h00; q <= {~q[0],q[7:1]}.
  - mode 4, interleaved on/off left: seed 8'h00; q <= {q[6:0],~q[7]}.
  - mode 5, bounce: seed 8'h01; shift left until q=8'h80, then right until 8'h01, and repeat.
REQ-018 Mode 5 SHALL reverse direction on the step that leaves an end: 80 is followed by 40, and 01 is followed by 02. Each end value is held for exactly one step.
REQ-019 In RUN, en=0 SHALL move to PAUSE on that edge, with no step on that edge.
REQ-020 In PAUSE, q and the prescaler count SHALL hold and tick=0; en=1 returns to RUN and counting resumes from the held count.
REQ-021 mode_req coincident with a prescaler wrap in RUN SHALL take priority: no step, and q is reloaded in LOAD.
REQ-022 mode_req and en=0 in the same RUN cycle SHALL go to LOAD, then to PAUSE.
REQ-023 In IDLE, q SHALL be 8'h00 and tick=0.
REQ-024 active SHALL equal (state==RUN), and tick SHALL be 0 outside RUN.

Reset
REQ-025 reset=0 SHALL immediately set all of the following, independent of clk: state=IDLE, q=8'h00, mode_ack=0, tick=0, active=0, prescaler=0, latched mode=0, direction=left.
REQ-026 Deasserting reset SHALL take effect on the next rising edge, with the FSM in IDLE awaiting a request.
REQ-027 Reset asserted mid-operation SHALL abort any load or pause with no residual tick or ack.

Verification (PRESCALE=4)
REQ-028 Mode 3 sequence:
  - stimulus: reset release, then mode=3, en=1, one-cycle mode_req;
  - response: mode_ack one cycle later; q=00 after LOAD, then one step per 4 cycles: 80, C0, E0, F0, F8, FC, FE, FF, 7F, 3F, ..., 01, 00, with a 16-step period.
REQ-029 Mode 5 sequence:
  - stimulus: mode=5, en=1;
  - response: q = 01, 02, 04, ..., 80, 40, ..., 01, 02; exactly one 80 and one 01 per sweep.
REQ-030 Pause and resume:
  - stimulus: en=0 for 10 cycles, two cycles after a tick in mode 1;
  - response: q frozen and active=0; after en=1 the next tick arrives after the remaining 2 counts, not 4.
REQ-031 Request collides with step:
  - stimulus: mode_req for mode 2 on the same cycle as a prescaler wrap in mode 1;
  - response: no mode-1 step; q=80 after LOAD; ack pulses once.
REQ-032 Reset and reserved mode:
  - stimulus: reset low mid-RUN with q=F0;
  - response: q=00 and active=0 immediately, with no tick until a new request.
  - stimulus: then mode=6;
  - response: ack, q=00, FSM returns to IDLE.
